// File: rtl/step_planner.sv
`timescale 1ns/1ps
// step_planner: walks a tracked (cur_x, cur_y) onto a latched 16x16 target with bounded x-then-y step commands.
// Latency: first command the cycle after start; one bubble per axis change, one more before the done pulse.
// Backpressure: while cmd_valid && !cmd_ready every cmd_* field and cur_* hold; a transfer updates cur_* by +/-cmd_step.
// Ports: clk, rst_n (async, active-low); start/tgt_x/tgt_y request a move (sampled in IDLE only);
//        cmd_valid/cmd_ready/cmd_axis/cmd_step/cmd_op carry step commands; cur_x/cur_y, busy, done report progress.
// Option: define STEP_PLANNER_ABORT_EN to add input abort, which cancels a move in X_MOVE/Y_MOVE without a done pulse.
module step_planner #(
  parameter int MAX_STEP = 3,
  parameter int START_X  = 0,
  parameter int START_Y  = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] tgt_x,
  input  logic [3:0] tgt_y,
`ifdef STEP_PLANNER_ABORT_EN
  input  logic       abort,
`endif
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic       cmd_axis,
  output logic [1:0] cmd_step,
  output logic       cmd_op,
  output logic [3:0] cur_x,
  output logic [3:0] cur_y,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, X_MOVE, Y_MOVE, DONE} state_t;

  typedef struct packed {
    logic       vld;
    logic       op;
    logic [1:0] step;
  } plan_t;

  // Next command for one axis: direction from the sign of the 5-bit
  // difference, magnitude clipped to MAX_STEP. Because the step never
  // exceeds the remaining distance, cur_* can never wrap.
  function automatic plan_t plan_step(input logic [3:0] cur, input logic [3:0] tgt);
    logic signed [4:0] diff;
    logic signed [4:0] mag;
    plan_t             p;
    diff   = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    mag    = diff[4] ? -diff : diff;
    p.vld  = (diff != 5'sd0);
    p.op   = diff[4];
    p.step = (mag > 5'(MAX_STEP)) ? 2'(MAX_STEP) : mag[1:0];
    return p;
  endfunction

  function automatic logic [3:0] apply_step(input logic [3:0] cur, input logic op,
                                            input logic [1:0] step);
    return op ? (cur - {2'b00, step}) : (cur + {2'b00, step});
  endfunction

  state_t     state_q, state_d;
  logic [3:0] tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
  logic [3:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic       cmd_valid_q, cmd_valid_d;
  logic       cmd_axis_q, cmd_axis_d;
  logic [1:0] cmd_step_q, cmd_step_d;
  logic       cmd_op_q, cmd_op_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic       hs;
  logic       load;
  plan_t      p;

  always_comb begin
    state_d     = state_q;
    tgt_x_d     = tgt_x_q;
    tgt_y_d     = tgt_y_q;
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    cmd_valid_d = cmd_valid_q;
    cmd_axis_d  = cmd_axis_q;
    cmd_step_d  = cmd_step_q;
    cmd_op_d    = cmd_op_q;
    done_d      = 1'b0;
    load        = 1'b0;
    p           = '0;
    hs          = cmd_valid_q && cmd_ready;

    // The accepted command moves the tracked position at this edge; the
    // next command below is planned from that post-update position.
    if (hs) begin
      if (cmd_axis_q) cur_y_d = apply_step(cur_y_q, cmd_op_q, cmd_step_q);
      else            cur_x_d = apply_step(cur_x_q, cmd_op_q, cmd_step_q);
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          tgt_x_d    = tgt_x;
          tgt_y_d    = tgt_y;
          state_d    = X_MOVE;
          p          = plan_step(cur_x_q, tgt_x);
          cmd_axis_d = 1'b0;
          load       = 1'b1;
        end
      end
      X_MOVE: begin
        // cmd_valid low here means x already sits on target (bubble cycle).
        if (!cmd_valid_q) begin
          state_d    = Y_MOVE;
          p          = plan_step(cur_y_q, tgt_y_q);
          cmd_axis_d = 1'b1;
          load       = 1'b1;
        end else if (hs) begin
          p    = plan_step(cur_x_d, tgt_x_q);
          load = 1'b1;
        end
      end
      Y_MOVE: begin
        if (!cmd_valid_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (hs) begin
          p    = plan_step(cur_y_d, tgt_y_q);
          load = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (load) begin
      cmd_valid_d = p.vld;
      cmd_op_d    = p.op;
      cmd_step_d  = p.step;
    end

`ifdef STEP_PLANNER_ABORT_EN
    // A transfer on the abort edge still lands (cur_* already updated above).
    if (abort && (state_q == X_MOVE || state_q == Y_MOVE)) begin
      state_d     = IDLE;
      cmd_valid_d = 1'b0;
      done_d      = 1'b0;
    end
`endif

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tgt_x_q     <= 4'(START_X);
      tgt_y_q     <= 4'(START_Y);
      cur_x_q     <= 4'(START_X);
      cur_y_q     <= 4'(START_Y);
      cmd_valid_q <= 1'b0;
      cmd_axis_q  <= 1'b0;
      cmd_step_q  <= 2'd0;
      cmd_op_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tgt_x_q     <= tgt_x_d;
      tgt_y_q     <= tgt_y_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_axis_q  <= cmd_axis_d;
      cmd_step_q  <= cmd_step_d;
      cmd_op_q    <= cmd_op_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_axis  = cmd_axis_q;
  assign cmd_step  = cmd_step_q;
  assign cmd_op    = cmd_op_q;
  assign cur_x     = cur_x_q;
  assign cur_y     = cur_y_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_step_planner.sv
`timescale 1ns/1ps
// tb_step_planner: directed moves checked against a command-list model every cycle,
// plus literal per-cycle expectations for the forward, reverse, null, reset and abort cases.
module tb_step_planner;

  localparam int MAX     = 3;
  localparam int K_CODE  = 0;
  localparam int K_POS   = 1;
  localparam int K_DONES = 2;
  localparam int K_RST   = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] tgt_x, tgt_y;
  logic       cmd_valid, cmd_ready, cmd_axis, cmd_op;
  logic [1:0] cmd_step;
  logic [3:0] cur_x, cur_y;
  logic       busy, done;
`ifdef STEP_PLANNER_ABORT_EN
  logic       abort;
`endif

  always #5 clk = ~clk;

  step_planner #(.MAX_STEP(MAX), .START_X(0), .START_Y(0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .tgt_x    (tgt_x),
    .tgt_y    (tgt_y),
`ifdef STEP_PLANNER_ABORT_EN
    .abort    (abort),
`endif
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_axis (cmd_axis),
    .cmd_step (cmd_step),
    .cmd_op   (cmd_op),
    .cur_x    (cur_x),
    .cur_y    (cur_y),
    .busy     (busy),
    .done     (done)
  );

  // ---------------- model: list of commands a move must produce ----------------
  typedef struct {
    logic axis;
    logic op;
    int   step;
  } exp_cmd_t;

  exp_cmd_t exp_q[$];
  int       mdl_x, mdl_y, done_cnt;
  logic     m_active;
  int       n_chk = 0;
  int       n_err = 0;

  // literal expectation posted by the stimulus for the current cycle
  logic     lit_en;
  int       lit_kind, lit_exp;
  string    lit_name;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void plan_axis(input logic axis, input int from, input int to);
    int p, d, s;
    p = from;
    while (p != to) begin
      d = to - p;
      s = (d < 0) ? -d : d;
      if (s > MAX) s = MAX;
      exp_q.push_back('{axis, d < 0, s});
      p += (d < 0) ? -s : s;
    end
  endfunction

  always @(negedge clk) begin
    exp_cmd_t h;
    logic     was_active;
    int       act;
    if (lit_en) begin
      case (lit_kind)
        K_CODE:  act = (done ? 1000 : 0) +
                       (cmd_valid ? 100 + (cmd_axis ? 10 : 0) + (cmd_op ? 4 : 0) + int'(cmd_step) : 0);
        K_POS:   act = int'(cur_x) * 16 + int'(cur_y);
        K_DONES: act = done_cnt;
        default: act = int'({cmd_valid, cmd_axis, cmd_step, cmd_op, busy, done, cur_x, cur_y});
      endcase
      check(lit_name, act, lit_exp);
    end
    if (!rst_n) begin
      exp_q.delete();
      mdl_x    = 0;
      mdl_y    = 0;
      m_active = 1'b0;
    end else begin
      was_active = m_active;
      check("cur_x", int'(cur_x), mdl_x);
      check("cur_y", int'(cur_y), mdl_y);
      check("busy", int'(busy), int'(m_active));
      if (cmd_valid) begin
        check("cmd_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          h = exp_q[0];
          check("cmd_axis", int'(cmd_axis), int'(h.axis));
          check("cmd_op", int'(cmd_op), int'(h.op));
          check("cmd_step", int'(cmd_step), h.step);
          if (cmd_ready) begin
            if (h.axis) mdl_y += h.op ? -h.step : h.step;
            else        mdl_x += h.op ? -h.step : h.step;
            void'(exp_q.pop_front());
          end
        end
      end
      if (done) begin
        check("done_when_complete", int'(m_active && exp_q.size() == 0), 1);
        done_cnt++;
        m_active = 1'b0;
      end
`ifdef STEP_PLANNER_ABORT_EN
      if (abort && was_active && !done) begin
        exp_q.delete();
        m_active = 1'b0;
      end
`endif
      if (start && !was_active) begin
        plan_axis(1'b0, mdl_x, int'(tgt_x));
        plan_axis(1'b1, mdl_y, int'(tgt_y));
        m_active = 1'b1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    lit_en = 1'b0;
  endtask

  task automatic post(input int kind, input int exp, input string name);
    lit_kind = kind;
    lit_exp  = exp;
    lit_name = name;
    lit_en   = 1'b1;
  endtask

  // code = 1000*done + (cmd_valid ? 100 + 10*axis + 4*op + step : 0), one entry per cycle after start
  task automatic run_tab(input int tx, input int ty, input int tab[$], input string name,
                         input int rdy_at);
    start     = 1'b1;
    tgt_x     = 4'(tx);
    tgt_y     = 4'(ty);
    cmd_ready = (rdy_at == 0);
    for (int i = 0; i < tab.size(); i++) begin
      tick();
      start = 1'b0;
      if (i == rdy_at) cmd_ready = 1'b1;
      post(K_CODE, tab[i], $sformatf("%s_cyc%0d", name, i + 1));
    end
  endtask

  int fwd[$] = '{103, 102, 0, 112, 0, 1000, 0};
  int rev[$] = '{107, 107, 107, 107, 106, 0, 0, 1000, 0};
  int nul[$] = '{0, 0, 1000, 0};

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    tgt_x     = 4'd0;
    tgt_y     = 4'd0;
    cmd_ready = 1'b1;
    lit_en    = 1'b0;
    done_cnt  = 0;
`ifdef STEP_PLANNER_ABORT_EN
    abort     = 1'b0;
`endif
    tick();
    post(K_RST, 0, "reset_state");
    tick();
    rst_n = 1'b1;
    tick();

    run_tab(5, 2, fwd, "fwd", 0);
    tick();
    post(K_POS, 5 * 16 + 2, "fwd_pos");

    tick();
    run_tab(0, 2, rev, "rev", 3);
    tick();
    post(K_POS, 0 * 16 + 2, "rev_pos");

    tick();
    run_tab(0, 2, nul, "null", 0);
    tick();
    post(K_DONES, 3, "done_count_after_null");

    // second start mid-move must be ignored
    tick();
    start = 1'b1; tgt_x = 4'd7; tgt_y = 4'd3; cmd_ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; tgt_x = 4'd9; tgt_y = 4'd9;
    tick();
    start = 1'b0;
    for (int k = 0; k < 40 && busy; k++) tick();
    post(K_POS, 7 * 16 + 3, "busy_start_pos");
    tick();
    post(K_DONES, 4, "busy_start_done_once");

    // reset while a command is pending
    tick();
    start = 1'b1; tgt_x = 4'd15; tgt_y = 4'd15;
    tick();
    start = 1'b0;
    post(K_CODE, 103, "pre_reset_cmd");
    tick();
    rst_n = 1'b0;
    post(K_RST, 0, "reset_mid_move");
    tick();
    rst_n = 1'b1;
    tick();

`ifdef STEP_PLANNER_ABORT_EN
    start = 1'b1; tgt_x = 4'd8; tgt_y = 4'd0; cmd_ready = 1'b1;
    tick();
    start = 1'b0;
    post(K_CODE, 103, "abort_cmd1");
    tick();
    abort = 1'b1;
    post(K_CODE, 103, "abort_cmd2");
    tick();
    abort = 1'b0;
    post(K_CODE, 0, "abort_idle");
    tick();
    post(K_POS, 6 * 16 + 0, "abort_pos");
    tick();
    post(K_DONES, 4, "abort_no_done");
`endif

    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/step_planner.md
# step_planner

Command source for the grid position datapath. It takes a target (x, y) cell on the 16x16 grid and issues a sequence of bounded step commands (axis, magnitude 1..MAX_STEP, add/subtract) over a valid/ready handshake. The downstream position updater applies each command as `pos ± step`. The block tracks its own copy of the current position, so the command stream always lands exactly on the target.

## Interface
Parameters:
- MAX_STEP, 3: largest step magnitude per command; legal 1..3, fits the 2-bit step field.
- START_X, 0: x position loaded at reset.
- START_Y, 0: y position loaded at reset.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request a move; sampled only in IDLE.
- tgt_x  in  4  target x; latched with start.
- tgt_y  in  4  target y; latched with start.
- cmd_valid  out  1  command on cmd_* is valid.
- cmd_ready  in  1  downstream accepts the command.
- cmd_axis  out  1  0 = x, 1 = y.
- cmd_step  out  2  step magnitude, 1..MAX_STEP when valid.
- cmd_op  out  1  0 = add, 1 = subtract (carry-in/complement select downstream).
- cur_x  out  4  tracked x position.
- cur_y  out  4  tracked y position.
- busy  out  1  high in X_MOVE, Y_MOVE and DONE.
- done  out  1  one-cycle pulse when target reached.

## Operation
- States: IDLE, X_MOVE, Y_MOVE, DONE.
- IDLE:
  - start=1 latches tgt_x/tgt_y and enters X_MOVE.
  - start=0 stays.
- X_MOVE:
  - cur_x == tgt_x: cmd_valid=0, go to Y_MOVE.
  - Otherwise: cmd_valid=1, cmd_axis=0, cmd_op=(tgt_x < cur_x), cmd_step=min(|tgt_x − cur_x|, MAX_STEP).
- Y_MOVE: identical on the y axis (cmd_axis=1). cur_y == tgt_y goes to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Handshake: transfer occurs on a clock edge with cmd_valid && cmd_ready. At that edge cur_x/cur_y update by ±cmd_step.
- While cmd_valid && !cmd_ready: cmd_axis, cmd_step, cmd_op and cur_* hold stable, and cmd_valid stays high.
- Arithmetic:
  - Differences are computed 5-bit signed.
  - Step is never larger than the remaining distance, so cur_* never wraps or overshoots. Any wrap is a design error.
- start while busy is ignored; tgt latches are not overwritten.
- Target equal to current position: X_MOVE → Y_MOVE → DONE with no commands; done still pulses.
- Reset mid-operation: returns immediately to IDLE. Any pending command is dropped with no handshake.

## Timing
- Reset values:
  - state IDLE
  - cmd_valid=0, cmd_axis=0, cmd_step=0, cmd_op=0
  - cur_x=START_X, cur_y=START_Y
  - busy=0, done=0
- All outputs are registered.
- cmd_valid rises the cycle after start is sampled, provided the x distance is non-zero.
- Throughput is one command per cycle while cmd_ready=1. The next command's fields are computed from the post-update position.
- Axis change costs one bubble cycle (cmd_valid=0). Entry to DONE costs one further cycle. done is asserted the cycle after that.
- busy drops in the same cycle IDLE is re-entered. A new start is accepted in that cycle.

## Configuration
- STEP_PLANNER_ABORT_EN defined: adds input `abort` (1 bit).
  - abort=1 in X_MOVE/Y_MOVE with no handshake that edge: go to IDLE, cmd_valid=0 next cycle.
  - abort coincident with a handshake: the transfer completes and cur_* updates, then go to IDLE.
  - done is never pulsed on abort. abort is ignored in IDLE and DONE.
- Undefined: no abort port; a move always runs to completion.

## Test plan
- Reset: assert rst_n=0 mid-X_MOVE with cmd_valid=1 → next sample shows cmd_valid=0, busy=0, cur=(START_X,START_Y)=(0,0).
- Forward move: from (0,0), start with tgt=(5,2), cmd_ready=1 → commands x+3, x+2, bubble, y+2, bubble, done pulse; cur=(5,2).
- Reverse move with backpressure: from (5,2), tgt=(0,2), cmd_ready low 3 cycles on the first command → x−3 held stable for 4 cycles, then x−2; cur=(0,2); no y commands.
- Null move: tgt equal to current → zero handshakes, done pulses exactly once 3 cycles after start.
- start while busy: second start with tgt=(9,9) mid-move → ignored; the first target is reached.
- With STEP_PLANNER_ABORT_EN: abort asserted during the second x command, coincident with cmd_ready=1 → that step is applied, return to IDLE, no done pulse.
